// File: rtl/hilo_mult_sequencer.sv
// Iterative shift-add multiplier with HI/LO pair: mult, multu, madd, msub, mthi, mtlo.
// Define EARLY_TERMINATE_EN to leave CALC as soon as the remaining multiplier is zero.
module hilo_mult_sequencer #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ReadHiLo,
  input  logic             Abort,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             Stall
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam int P_W   = 2 * WIDTH;

  typedef enum logic [2:0] {
    OP_NOP, OP_MULT, OP_MULTU, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO, OP_RSVD
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e           r_state;
  op_e              r_op;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [P_W-1:0]   r_acc;
  logic [P_W-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_count;
  logic             r_neg;
  logic             r_busy;
  logic             r_done;

  op_e              w_op;
  logic             w_signed;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH-1:0] w_mplier_next;
  logic [P_W-1:0]   w_partial;
  logic [P_W-1:0]   w_prod;
  logic [P_W-1:0]   w_commit;
  logic             w_last;

  assign w_op          = op_e'(Op);
  assign w_signed      = (w_op != OP_MULTU);
  assign w_a_mag       = (w_signed && A[WIDTH-1]) ? -A : A;
  assign w_b_mag       = (w_signed && B[WIDTH-1]) ? -B : B;
  assign w_mplier_next = r_mplier >> BITS_PER_CYCLE;

`ifdef EARLY_TERMINATE_EN
  assign w_last = (r_count == CNT_W'(1)) || (w_mplier_next == '0);
`else
  assign w_last = (r_count == CNT_W'(1));
`endif

  // The multiplicand register is pre-shifted each cycle, so bit j of the
  // current multiplier slice always weighs r_mcand << j.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
    end
  end

  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    case (r_op)
      OP_MADD: w_commit = {r_hi, r_lo} + w_prod;
      OP_MSUB: w_commit = {r_hi, r_lo} - w_prod;
      default: w_commit = w_prod;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_IDLE;
      r_op     <= OP_NOP;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start && !Abort) begin
            case (w_op)
              OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                r_op     <= w_op;
                r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                r_mplier <= w_b_mag;
                r_neg    <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                r_acc    <= '0;
                r_count  <= CNT_W'(N);
                r_busy   <= 1'b1;
                r_state  <= S_CALC;
              end
              OP_MTHI: r_hi <= A;
              OP_MTLO: r_lo <= A;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          if (Abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc    <= r_acc + w_partial;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= w_mplier_next;
            r_count  <= r_count - CNT_W'(1);
            if (w_last) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!Abort) begin
            {r_hi, r_lo} <= w_commit;
            r_done       <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign HI    = r_hi;
  assign LO    = r_lo;
  assign Busy  = r_busy;
  assign Done  = r_done;
  assign Stall = r_busy & (Start | ReadHiLo);

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Directed bench for hilo_mult_sequencer: latency, HI/LO results, stall, abort and reset.
module tb_hilo_mult_sequencer;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start = 1'b0;
  logic [2:0]   Op = 3'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         ReadHiLo = 1'b0;
  logic         Abort = 1'b0;
  logic [W-1:0] HI, LO;
  logic         Busy, Done, Stall;

  int errors = 0;
  int checks = 0;
  int n_busy;
  int n_done;

`ifdef EARLY_TERMINATE_EN
  localparam int LAT_ONE = 2;
`else
  localparam int LAT_ONE = 33;
`endif

  hilo_mult_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .ReadHiLo(ReadHiLo), .Abort(Abort), .HI(HI), .LO(LO),
    .Busy(Busy), .Done(Done), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; Op = 3'd0;
  endtask

  // Counts cycles with Busy high (bounded) and Done pulses seen meanwhile.
  task automatic run_to_done(output int busy_cycles, output int done_seen);
    busy_cycles = 0;
    done_seen   = 0;
    while (Busy === 1'b1 && busy_cycles < 200) begin
      if (Done === 1'b1) done_seen++;
      busy_cycles++;
      @(negedge Clk);
    end
    if (busy_cycles >= 200) check("busy_timeout", 64'(busy_cycles), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_hi", 64'(HI), 64'h0);
    check("rst_lo", 64'(LO), 64'h0);
    check("rst_busy", 64'(Busy), 64'h0);
    check("rst_done", 64'(Done), 64'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step(1);

    // MULT -3 * 7
    issue(3'd1, 32'hFFFF_FFFD, 32'd7);
    check("mult_busy_start", 64'(Busy), 64'h1);
    run_to_done(n_busy, n_done);
    check("mult_latency", 64'(n_busy), 64'd33);
    check("mult_done_early", 64'(n_done), 64'd0);
    check("mult_done", 64'(Done), 64'h1);
    check("mult_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    step(1);
    check("mult_done_once", 64'(Done), 64'h0);

    // MULTU max * max
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_to_done(n_busy, n_done);
    check("multu_hilo", {HI, LO}, 64'hFFFF_FFFE_0000_0001);

    // MTHI / MTLO then MADD 2*3
    Start = 1'b1; Op = 3'd5; A = 32'h1234_5678;
    #1 check("mthi_no_stall", 64'(Stall), 64'h0);
    @(negedge Clk);
    Start = 1'b0;
    check("mthi_no_busy", 64'(Busy), 64'h0);
    check("mthi_hi", 64'(HI), 64'h1234_5678);
    issue(3'd6, 32'h9ABC_DEF0, '0);
    check("mtlo_lo", 64'(LO), 64'h9ABC_DEF0);
    issue(3'd3, 32'd2, 32'd3);
    run_to_done(n_busy, n_done);
    check("madd_hilo", {HI, LO}, 64'h1234_5678_9ABC_DEF6);

    // MSUB 1*1 from zero wraps
    issue(3'd5, 32'h0, '0);
    issue(3'd6, 32'h0, '0);
    issue(3'd4, 32'd1, 32'd1);
    run_to_done(n_busy, n_done);
    check("msub_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);

    // Reserved op ignored
    issue(3'd7, 32'hDEAD_BEEF, 32'h1);
    check("rsvd_no_busy", 64'(Busy), 64'h0);
    check("rsvd_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);

    // Stall: MTLO + ReadHiLo while MULT 5*6 in flight
    issue(3'd1, 32'd5, 32'd6);
    step(3);
    for (int i = 0; i < 3; i++) begin
      Start = 1'b1; Op = 3'd6; A = 32'h0000_AAAA; ReadHiLo = 1'b1;
      #1 check("stall_active", 64'(Stall), 64'h1);
      check("stall_old_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge Clk);
    end
    Start = 1'b0; Op = 3'd0; ReadHiLo = 1'b0;
    #1 check("stall_idle_inputs", 64'(Stall), 64'h0);
    ReadHiLo = 1'b1;
    #1 check("stall_readhilo_only", 64'(Stall), 64'h1);
    ReadHiLo = 1'b0;
    run_to_done(n_busy, n_done);
    check("stall_mult_hilo", {HI, LO}, 64'h0000_0000_0000_001E);
    check("stall_done", 64'(Done), 64'h1);

    // Abort at CALC cycle 10 of MULT 9*9
    issue(3'd5, 32'h11, '0);
    issue(3'd6, 32'h11, '0);
    issue(3'd1, 32'd9, 32'd9);
    step(9);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    check("abort_busy", 64'(Busy), 64'h0);
    check("abort_done", 64'(Done), 64'h0);
    check("abort_hilo", {HI, LO}, 64'h0000_0011_0000_0011);
    step(1);
    check("abort_done_later", 64'(Done), 64'h0);

    // Abort and Start together in IDLE: command dropped
    Abort = 1'b1;
    issue(3'd5, 32'h55, '0);
    Abort = 1'b0;
    check("abort_start_hi", 64'(HI), 64'h11);
    check("abort_start_busy", 64'(Busy), 64'h0);

    // MULTU 0x1234*1 then back-to-back MULT 2*-1 in the Done cycle
    issue(3'd2, 32'h1234, 32'd1);
    run_to_done(n_busy, n_done);
    check("multu1_latency", 64'(n_busy), 64'(LAT_ONE));
    check("multu1_hilo", {HI, LO}, 64'h0000_0000_0000_1234);
    check("multu1_done", 64'(Done), 64'h1);
    issue(3'd1, 32'd2, 32'hFFFF_FFFF);
    check("b2b_busy", 64'(Busy), 64'h1);
    run_to_done(n_busy, n_done);
    check("b2b_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);

    // Asynchronous reset mid-CALC
    issue(3'd1, 32'd9, 32'd9);
    step(5);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_hilo", {HI, LO}, 64'h0);
    check("arst_busy", 64'(Busy), 64'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step(2);
    check("arst_stays_idle", 64'(Busy), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_mult_sequencer.md
Name: hilo_mult_sequencer

Overview:
- Multi-cycle iterative multiply unit with HI/LO register pair for the MIPS datapath.
- Sequences mult, multu, madd and msub as a shift-add loop over several cycles.
- Services mthi/mtlo directly.
- Supplies HI/LO to the mfhi/mflo path and raises a pipeline stall while a product is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- BITS_PER_CYCLE, 1, multiplier bits retired per CALC cycle; must divide WIDTH; N = WIDTH/BITS_PER_CYCLE.

Ports:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous active-low reset
- Start  input  1  command valid, sampled on the rising edge
- Op  input  3  000 NOP, 001 MULT, 010 MULTU, 011 MADD, 100 MSUB, 101 MTHI, 110 MTLO, 111 reserved
- A  input  WIDTH  rs operand (multiplicand); data for MTHI/MTLO
- B  input  WIDTH  rt operand (multiplier)
- ReadHiLo  input  1  an mfhi/mflo is in decode
- Abort  input  1  pipeline flush
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register
- Busy  output  1  multiply in progress
- Done  output  1  one-cycle pulse when a multiply commits
- Stall  output  1  combinational: Busy & (Start | ReadHiLo)

Behaviour:
- Reset (async, Reset_n=0):
  - HI=0, LO=0, Busy=0, Done=0, state IDLE.
  - An operation in progress is discarded.
- States: IDLE, CALC, FIX.
- IDLE, Start=1:
  - Op 001–100: latch |A|, |B| (raw values for MULTU), result sign = A[msb]^B[msb] (0 for MULTU), and Op. Clear the product accumulator. Set iteration count to N. Go to CALC; Busy=1 from the next cycle.
  - Op 101: HI<=A at that edge. Op 110: LO<=A. No Busy for either.
  - Op 000 and 111: ignored.
- CALC, each cycle:
  - Add multiplicand shifted by the iteration position times the low BITS_PER_CYCLE multiplier bits into the 2*WIDTH-bit accumulator.
  - Shift the multiplier right by BITS_PER_CYCLE; decrement the count.
  - Go to FIX after the N-th cycle.
- FIX, one cycle:
  - Negate the product if the sign bit is set.
  - MULT/MULTU: {HI,LO} <= P.
  - MADD: {HI,LO} <= {HI,LO} + P. MSUB: {HI,LO} <= {HI,LO} - P.
  - All arithmetic is modulo 2^(2*WIDTH); no overflow flag.
  - Return to IDLE.
- Timing: Start accepted at edge E0 -> HI/LO updated at edge E(N+1). Busy falls and Done=1 in the cycle after E(N+1). Default config: N+1 = 33 edges.
- Start while Busy:
  - Ignored, including MTHI/MTLO.
  - Stall=1 so the pipeline holds and re-presents the instruction.
- ReadHiLo while Busy: Stall=1. HI/LO always show the last committed values and never a partial product.
- Abort in CALC or FIX:
  - Return to IDLE at the next edge with HI/LO unchanged.
  - No Done. Busy=0 next cycle.
  - Abort in IDLE has no effect.
- Abort and Start in the same IDLE cycle: Abort wins, command dropped.
- Start in the cycle Done is high: accepted normally; back-to-back operation allowed.

Optional Feature:
- Macro: EARLY_TERMINATE_EN.
- Defined:
  - At each CALC cycle, if the remaining shifted multiplier is zero, go to FIX immediately.
  - Minimum one CALC cycle.
  - Latency = (number of CALC cycles) + 1.
- Undefined: CALC always runs exactly N cycles (fixed latency).
- Results are identical either way.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Busy for 33 cycles; Done pulse once, immediately after.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0, then MADD 2*3 -> HI=0x12345678, LO=0x9ABCDEF6. Then MTHI 0, MTLO 0, MSUB 1*1 -> HI=LO=0xFFFFFFFF.
- MULT 5*6 in flight; at cycle 4 assert Start (MTLO 0xAAAA) with ReadHiLo=1 -> Stall=1 each such cycle, MTLO ignored. Final HI=0, LO=30; old HI/LO visible until commit.
- Abort at CALC cycle 10 of MULT 9*9 with prior HI=LO=0x11 -> Busy=0 next cycle, no Done, HI=LO=0x11. Separately, Reset_n low mid-CALC -> HI=LO=0, Busy=0 immediately.
- With EARLY_TERMINATE_EN: MULTU 0x1234*1 -> Done 2 edges + 1 cycle after Start, LO=0x1234, HI=0. Without the macro, same op -> 33-edge latency, same result.
